// File: rtl/btn_event_decoder.sv
// Decodes a debounced button level into short-press, long-press and auto-repeat
// single-cycle events, plus a level that stays high while the button is long-held.
module btn_event_decoder #(
  parameter int ACTIVE_LOW    = 1,
  parameter int LONG_CYCLES   = 27000000,
  parameter int REPEAT_CYCLES = 5400000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_short,
  output logic o_long,
  output logic o_repeat,
  output logic o_held
);

  // state    | meaning
  // WAIT_REL | after reset: ignore the button until it is seen released
  // IDLE     | released, waiting for a press
  // PRESS    | pressed, counting toward the long-press threshold
  // LONG     | long press reached, counting auto-repeat periods

  localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CTR_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CTR_W-1:0] LONG_LAST   = CTR_W'(LONG_CYCLES - 1);
  localparam logic [CTR_W-1:0] REPEAT_LAST = CTR_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
  localparam logic [CTR_W-1:0] CTR_ONE     = CTR_W'(1);
  localparam logic             REPEAT_EN   = (REPEAT_CYCLES != 0);
  localparam logic             ACT_LVL     = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    IDLE     = 2'd1,
    PRESS    = 2'd2,
    LONG     = 2'd3
  } state_t;

  state_t           state;
  logic [CTR_W-1:0] ctr;
  logic             pressed;

  assign pressed = i_btn ^ ACT_LVL;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= WAIT_REL;
      ctr      <= '0;
      o_short  <= 1'b0;
      o_long   <= 1'b0;
      o_repeat <= 1'b0;
      o_held   <= 1'b0;
    end else begin
      o_short  <= 1'b0;
      o_long   <= 1'b0;
      o_repeat <= 1'b0;
      case (state)
        WAIT_REL: begin
          ctr <= '0;
          if (!pressed) state <= IDLE;
        end
        IDLE: begin
          if (pressed) begin
            state <= PRESS;
            ctr   <= CTR_ONE;
          end else begin
            ctr <= '0;
          end
        end
        PRESS: begin
          // release wins over reaching the threshold on the same edge
          if (!pressed) begin
            state   <= IDLE;
            ctr     <= '0;
            o_short <= 1'b1;
          end else if (ctr == LONG_LAST) begin
            state  <= LONG;
            ctr    <= '0;
            o_long <= 1'b1;
            o_held <= 1'b1;
          end else begin
            ctr <= ctr + CTR_ONE;
          end
        end
        LONG: begin
          if (!pressed) begin
            state  <= IDLE;
            ctr    <= '0;
            o_held <= 1'b0;
          end else if (REPEAT_EN && (ctr == REPEAT_LAST)) begin
            ctr      <= '0;
            o_repeat <= 1'b1;
          end else if (REPEAT_EN) begin
            ctr <= ctr + CTR_ONE;
          end else begin
            ctr <= '0;
          end
        end
        default: begin
          state  <= WAIT_REL;
          ctr    <= '0;
          o_held <= 1'b0;
        end
      endcase
    end
  end

endmodule
